// File: rtl/ctrl_relogio.sv
// Clock control FSM: run / set-hour / set-minute with edge-detected buttons.
// Optional inactivity timeout in set modes is built when CTRL_RELOGIO_TIMEOUT_EN is defined.
module ctrl_relogio #(
  parameter int TIMEOUT_S = 10
) (
  input  logic       ctrl_relogio_clock,
  input  logic       ctrl_relogio_reset,
  input  logic       ctrl_relogio_enable1hz,
  input  logic       ctrl_relogio_btn_modo,
  input  logic       ctrl_relogio_btn_inc,
  input  logic       ctrl_relogio_incremento_minuto,
  output logic       ctrl_relogio_enable_s,
  output logic       ctrl_relogio_zera_s,
  output logic       ctrl_relogio_inc_min,
  output logic       ctrl_relogio_inc_hora,
  output logic [1:0] ctrl_relogio_modo,
  output logic       ctrl_relogio_pisca
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    AJ_HORA = 2'b01,
    AJ_MIN  = 2'b10
  } state_t;

  state_t state_r;
  logic   armed_r;
  logic   modo_prev_r;
  logic   inc_prev_r;
  logic   carry_prev_r;
  logic   inc_min_r;
  logic   inc_hora_r;
  logic   zera_s_r;
  logic   pisca_r;

  logic   modo_edge_s;
  logic   inc_edge_s;
  logic   carry_edge_s;
  logic   timeout_s;

  if (TIMEOUT_S < 1 || TIMEOUT_S > 15) begin : g_bad_timeout
    $error("ctrl_relogio: TIMEOUT_S must be in 1..15");
  end

  // armed_r masks the first clock after reset so a held button is not seen as an edge
  assign modo_edge_s  = armed_r & ctrl_relogio_btn_modo & ~modo_prev_r;
  assign inc_edge_s   = armed_r & ctrl_relogio_btn_inc  & ~inc_prev_r;
  assign carry_edge_s = armed_r & ctrl_relogio_incremento_minuto & ~carry_prev_r;

  assign ctrl_relogio_enable_s = ctrl_relogio_enable1hz & (state_r == RUN);
  assign ctrl_relogio_zera_s   = zera_s_r;
  assign ctrl_relogio_inc_min  = inc_min_r;
  assign ctrl_relogio_inc_hora = inc_hora_r;
  assign ctrl_relogio_modo     = state_r;
  assign ctrl_relogio_pisca    = pisca_r;

`ifdef CTRL_RELOGIO_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_S - 1);

  logic [3:0] timeout_cnt_r;

  // Fires on the tick that would bring the idle count up to TIMEOUT_S
  assign timeout_s = ctrl_relogio_enable1hz & (timeout_cnt_r == TIMEOUT_LAST) &
                     ~modo_edge_s & ~inc_edge_s & (state_r != RUN);

  // Inactivity counter: seconds without button activity while in a set mode
  always_ff @(posedge ctrl_relogio_clock or negedge ctrl_relogio_reset) begin
    if (!ctrl_relogio_reset) begin
      timeout_cnt_r <= 4'd0;
    end else if ((state_r != AJ_HORA && state_r != AJ_MIN) || modo_edge_s ||
                 inc_edge_s || timeout_s) begin
      timeout_cnt_r <= 4'd0;
    end else if (ctrl_relogio_enable1hz && timeout_cnt_r != 4'hF) begin
      timeout_cnt_r <= timeout_cnt_r + 4'd1;
    end else begin
      timeout_cnt_r <= timeout_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Mode FSM with registered one-cycle pulses and blink phase
  always_ff @(posedge ctrl_relogio_clock or negedge ctrl_relogio_reset) begin
    if (!ctrl_relogio_reset) begin
      state_r      <= RUN;
      armed_r      <= 1'b0;
      modo_prev_r  <= 1'b0;
      inc_prev_r   <= 1'b0;
      carry_prev_r <= 1'b0;
      inc_min_r    <= 1'b0;
      inc_hora_r   <= 1'b0;
      zera_s_r     <= 1'b0;
      pisca_r      <= 1'b0;
    end else begin
      armed_r      <= 1'b1;
      modo_prev_r  <= ctrl_relogio_btn_modo;
      inc_prev_r   <= ctrl_relogio_btn_inc;
      carry_prev_r <= ctrl_relogio_incremento_minuto;
      inc_min_r    <= 1'b0;
      inc_hora_r   <= 1'b0;
      zera_s_r     <= 1'b0;
      case (state_r)
        RUN: begin
          pisca_r <= 1'b0;
          if (modo_edge_s) begin
            state_r <= AJ_HORA;
          end else begin
            state_r   <= RUN;
            inc_min_r <= carry_edge_s;
          end
        end
        AJ_HORA: begin
          if (modo_edge_s) begin
            state_r <= AJ_MIN;
            pisca_r <= 1'b0;
          end else if (timeout_s) begin
            state_r <= RUN;
            pisca_r <= 1'b0;
          end else begin
            state_r    <= AJ_HORA;
            inc_hora_r <= inc_edge_s;
            pisca_r    <= pisca_r ^ ctrl_relogio_enable1hz;
          end
        end
        AJ_MIN: begin
          // Leaving minute-set restarts the seconds from zero
          if (modo_edge_s || timeout_s) begin
            state_r  <= RUN;
            zera_s_r <= 1'b1;
            pisca_r  <= 1'b0;
          end else begin
            state_r   <= AJ_MIN;
            inc_min_r <= inc_edge_s;
            pisca_r   <= pisca_r ^ ctrl_relogio_enable1hz;
          end
        end
        default: begin
          state_r <= RUN;
          pisca_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_relogio.sv
// Directed bench for ctrl_relogio; timeout expectations follow CTRL_RELOGIO_TIMEOUT_EN.
module tb_ctrl_relogio;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en1hz = 1'b0;
  logic       btn_modo = 1'b0;
  logic       btn_inc = 1'b0;
  logic       carry = 1'b0;
  logic       enable_s;
  logic       zera_s;
  logic       inc_min;
  logic       inc_hora;
  logic [1:0] modo;
  logic       pisca;

  int checks = 0;
  int errors = 0;
  int n_en = 0, n_zera = 0, n_imin = 0, n_ihora = 0;
  int b_en, b_zera, b_imin, b_ihora;

  ctrl_relogio #(.TIMEOUT_S(10)) dut (
    .ctrl_relogio_clock            (clk),
    .ctrl_relogio_reset            (rst_n),
    .ctrl_relogio_enable1hz        (en1hz),
    .ctrl_relogio_btn_modo         (btn_modo),
    .ctrl_relogio_btn_inc          (btn_inc),
    .ctrl_relogio_incremento_minuto(carry),
    .ctrl_relogio_enable_s         (enable_s),
    .ctrl_relogio_zera_s           (zera_s),
    .ctrl_relogio_inc_min          (inc_min),
    .ctrl_relogio_inc_hora         (inc_hora),
    .ctrl_relogio_modo             (modo),
    .ctrl_relogio_pisca            (pisca)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    n_en    <= n_en + int'(enable_s);
    n_zera  <= n_zera + int'(zera_s);
    n_imin  <= n_imin + int'(inc_min);
    n_ihora <= n_ihora + int'(inc_hora);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic base();
    b_en = n_en; b_zera = n_zera; b_imin = n_imin; b_ihora = n_ihora;
  endtask

  task automatic press_modo();
    btn_modo = 1'b1; step(); btn_modo = 1'b0; step();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; step(); btn_inc = 1'b0; step();
  endtask

  task automatic tick();
    en1hz = 1'b1; step(); en1hz = 1'b0; step();
  endtask

  initial begin
    btn_modo = 1'b1;
    step(3);
    chk("rst_modo", modo, 0);
    chk("rst_pisca", pisca, 0);
    chk("rst_pulses", {zera_s, inc_min, inc_hora}, 0);
    rst_n = 1'b1;
    step(3);
    chk("held_btn_no_edge", modo, 0);
    btn_modo = 1'b0;
    step(2);

    base();
    for (int i = 0; i < 3; i++) begin
      en1hz = 1'b1;
      #1;
      chk("enable_s_comb", enable_s, 1);
      step(); en1hz = 1'b0; step();
    end
    chk("run_en_count", n_en - b_en, 3);
    chk("run_modo", modo, 0);
    chk("run_pisca", pisca, 0);
    chk("run_other", (n_zera - b_zera) + (n_imin - b_imin) + (n_ihora - b_ihora), 0);

    base();
    carry = 1'b1;
    step();
    chk("carry_latency", inc_min, 1);
    step();
    chk("carry_one_cycle", inc_min, 0);
    step(48);
    carry = 1'b0;
    step(2);
    chk("carry_pulses", n_imin - b_imin, 1);

    base();
    press_inc();
    chk("inc_ignored_run", (n_imin - b_imin) + (n_ihora - b_ihora), 0);

    press_modo();
    chk("aj_hora_modo", modo, 1);
    chk("aj_hora_pisca0", pisca, 0);
    press_inc();
    press_inc();
    chk("inc_hora_count", n_ihora - b_ihora, 2);
    tick();
    chk("aj_hora_blink", pisca, 1);
    press_modo();
    chk("aj_min_modo", modo, 2);
    chk("pisca_clr_on_change", pisca, 0);
    carry = 1'b1; step(3); carry = 1'b0; step();
    chk("carry_ignored_set", n_imin - b_imin, 0);
    press_inc();
    chk("aj_min_inc", n_imin - b_imin, 1);
    chk("no_hora_in_min", n_ihora - b_ihora, 2);
    press_modo();
    chk("back_run_modo", modo, 0);
    chk("exit_zera", n_zera - b_zera, 1);

    press_modo();
    press_modo();
    chk("re_enter_min", modo, 2);
    base();
    btn_modo = 1'b1; btn_inc = 1'b1;
    step();
    chk("simul_modo", modo, 0);
    chk("simul_zera", zera_s, 1);
    btn_modo = 1'b0; btn_inc = 1'b0;
    step();
    chk("simul_zera_once", zera_s, 0);
    chk("simul_no_inc", n_imin - b_imin, 0);

    press_modo();
    press_modo();
    base();
    for (int i = 0; i < 9; i++) tick();
    chk("to_9_modo", modo, 2);
    chk("to_9_pisca", pisca, 1);
    en1hz = 1'b1; step(); en1hz = 1'b0;
`ifdef CTRL_RELOGIO_TIMEOUT_EN
    chk("to_10_modo", modo, 0);
    chk("to_10_zera", zera_s, 1);
    step();
`else
    chk("no_to_modo", modo, 2);
    chk("no_to_zera", zera_s, 0);
    step();
    press_modo();
    chk("no_to_exit", modo, 0);
`endif

    press_modo();
    tick();
    chk("pre_rst_pisca", pisca, 1);
    chk("pre_rst_modo", modo, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_modo", modo, 0);
    chk("async_rst_pisca", pisca, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_relogio.md
CTRL_RELOGIO -- requirements
Module: ctrl_relogio

Interface
REQ-001 Parameter: TIMEOUT_S, 10, seconds of button inactivity before set mode auto-exits; legal range 1..15.
REQ-002 ctrl_relogio_clock  input  1  system clock; all state updates on its rising edge.
REQ-003 ctrl_relogio_reset  input  1  reset, asynchronous, active-low.
REQ-004 ctrl_relogio_enable1hz  input  1  one-cycle tick, once per second.
REQ-005 ctrl_relogio_btn_modo  input  1  mode button; synchronous, debounced, active-high level.
REQ-006 ctrl_relogio_btn_inc  input  1  increment button; synchronous, debounced, active-high level.
REQ-007 ctrl_relogio_incremento_minuto  input  1  minute carry from the seconds counter; level held high for up to one second.
REQ-008 ctrl_relogio_enable_s  output  1  gated 1 Hz tick to the seconds counter.
REQ-009 ctrl_relogio_zera_s  output  1  one-cycle clear request to the seconds counter.
REQ-010 ctrl_relogio_inc_min  output  1  one-cycle increment pulse to the minute counter.
REQ-011 ctrl_relogio_inc_hora  output  1  one-cycle increment pulse to the hour counter.
REQ-012 ctrl_relogio_modo  output  2  current state: 00 RUN, 01 AJ_HORA, 10 AJ_MIN; 11 never driven.
REQ-013 ctrl_relogio_pisca  output  1  blink phase for the field being set.

Function
REQ-014 Button and carry edges: one-cycle-delayed copies of btn_modo, btn_inc and incremento_minuto are registered. An edge is detected in the cycle where input=1 and delayed copy=0.
REQ-015 Mode edge advances the state: RUN->AJ_HORA->AJ_MIN->RUN.
REQ-016 enable_s = enable1hz AND (state==RUN). It is combinational, with zero latency.
REQ-017 In RUN, a carry edge produces inc_min=1 in the following cycle. A carry held high produces exactly one pulse.
REQ-018 In AJ_HORA, an inc edge produces inc_hora=1 in the following cycle. In AJ_MIN, an inc edge produces inc_min=1 in the following cycle.
REQ-019 Inc edges in RUN and carry edges in AJ_HORA/AJ_MIN are ignored.
REQ-020 Transition AJ_MIN->RUN (by mode edge or timeout) produces zera_s=1 in the following cycle, so the seconds restart at 00.
REQ-021 Simultaneous mode and inc edges: the mode edge is honored and the inc edge is discarded.
REQ-022 pisca toggles on each enable1hz while in AJ_HORA or AJ_MIN. pisca is forced to 0 in RUN and is cleared on every state change.
REQ-023 Each of inc_min, inc_hora and zera_s is high for exactly one cycle per triggering event, never consecutively from a single event.
REQ-024 State register never holds 11. If 11 is ever decoded, the next state is RUN.

Reset
REQ-025 Reset assertion immediately forces the following, independent of clock:
- state = RUN
- inc_min, inc_hora, zera_s, pisca = 0
- edge registers = 0
- timeout counter = 0
REQ-026 Reset mid-set-mode discards any pending pulse. No zera_s is generated by reset.
REQ-027 After reset release, a button already held high is not detected as an edge, because the delayed copy loads on the first clock.

Configuration
REQ-028 Macro CTRL_RELOGIO_TIMEOUT_EN, when defined, enables the inactivity timeout:
- a 4-bit counter increments on enable1hz in AJ_HORA/AJ_MIN;
- it clears on any mode/inc edge, on state change and in RUN;
- when it reaches TIMEOUT_S, the state returns to RUN (with zera_s per REQ-020 if leaving AJ_MIN);
- a mode edge in the same cycle takes priority over the timeout.
REQ-029 When CTRL_RELOGIO_TIMEOUT_EN is undefined, no counter is built and set modes persist indefinitely.

Verification
REQ-030 Reset release, then 3 enable1hz ticks in RUN -> enable_s pulses 3 times; modo=00, pisca=0, all other outputs 0.
REQ-031 incremento_minuto held high for 50 cycles in RUN -> exactly one inc_min pulse, one cycle after its rising edge.
REQ-032 Mode press, then 2 inc presses -> modo=01 and 2 inc_hora pulses. Mode press, then 1 inc press -> modo=10 and 1 inc_min pulse. Mode press -> modo=00 and one zera_s pulse.
REQ-033 In AJ_MIN, btn_modo and btn_inc rise in the same cycle -> modo=00, zera_s pulse, no inc_min pulse.
REQ-034 With CTRL_RELOGIO_TIMEOUT_EN and TIMEOUT_S=10, enter AJ_MIN and apply 10 ticks with no buttons -> return to RUN and zera_s pulse after the 10th tick. Without the macro -> modo remains 10.
REQ-035 Reset asserted asynchronously in AJ_HORA with pisca=1 -> modo=00 and pisca=0 before the next clock edge.
